dma_engine: RTL

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine_pkg.sv | 15 +
 rtl/dma_engine.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dma_engine_pkg.sv
// Shared definitions for the byte-copy DMA engine: default widths and FSM state encoding.
package dma_engine_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

endpackage

// File: rtl/dma_engine.sv
// Byte-at-a-time memory-to-memory copy engine: read request, read data, write (3 cycles per byte).
// All strobes and status outputs are registered and driven from a single state machine.
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_ce,
  output logic              mem_w,
  output logic              mem_r,
  output logic              mem_oe
);

  state_t            state_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [7:0]        byte_reg;

  // The write data is the latched byte itself, so it holds its last value while idle.
  assign mem_wdata = byte_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      byte_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      mem_addr  <= '0;
      mem_ce    <= 1'b0;
      mem_w     <= 1'b0;
      mem_r     <= 1'b0;
      mem_oe    <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_ce <= 1'b0;
      mem_w  <= 1'b0;
      mem_r  <= 1'b0;
      mem_oe <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (start && !abort) begin
          busy      <= 1'b1;
          remaining <= len;
          if (len != '0) begin
            src_reg   <= src;
            dst_reg   <= dst;
            mem_addr  <= src;
            mem_ce    <= 1'b1;
            mem_r     <= 1'b1;
            state_reg <= ST_RD_REQ;
          end else begin
            done      <= 1'b1;
            state_reg <= ST_FIN;
          end
        end
      end else if (abort) begin
        // The write strobe of a WR cycle commits at this very edge, so that byte counts as written.
        state_reg <= ST_IDLE;
        busy      <= 1'b0;
        if (state_reg == ST_WR) begin
          remaining <= remaining - LEN_W'(1);
        end
      end else begin
        case (state_reg)
          ST_RD_REQ: begin
            mem_ce    <= 1'b1;
            mem_oe    <= 1'b1;
            state_reg <= ST_RD_DATA;
          end
          ST_RD_DATA: begin
            byte_reg  <= mem_rdata;
            mem_addr  <= dst_reg;
            mem_ce    <= 1'b1;
            mem_w     <= 1'b1;
            state_reg <= ST_WR;
          end
          ST_WR: begin
            src_reg   <= src_reg + ADDR_W'(1);
            dst_reg   <= dst_reg + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              done      <= 1'b1;
              state_reg <= ST_FIN;
            end else begin
              mem_addr  <= src_reg + ADDR_W'(1);
              mem_ce    <= 1'b1;
              mem_r     <= 1'b1;
              state_reg <= ST_RD_REQ;
            end
          end
          ST_FIN: begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
